// File: rtl/vpack.sv
// Scalar-stream to vector packer: collects INT_SIZE elements into VECTOR_SIZE-lane
// vectors with one fill buffer and one output register, flushing partials on in_last.
module vpack #(
  parameter int                  VECTOR_SIZE = 16,
  parameter int                  INT_SIZE    = 16,
  parameter logic [INT_SIZE-1:0] PAD_VALUE   = '0
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic [INT_SIZE-1:0]                    in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   out_vec,
  output logic [VECTOR_SIZE-1:0]                 out_mask,
  output logic [$clog2(VECTOR_SIZE):0]           out_count,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int CW = $clog2(VECTOR_SIZE);
  localparam int NW = CW + 1;

  typedef enum logic {
    S_FILL,
    S_FULL
  } state_t;

  state_t                                 state_q, state_d;
  logic                                   alive_q;
  logic [NW-1:0]                          cnt_q, cnt_d;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   buf_q, buf_d;
  logic [VECTOR_SIZE-1:0]                 mask_q, mask_d;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   ovec_q, ovec_d;
  logic [VECTOR_SIZE-1:0]                 omask_q, omask_d;
  logic [NW-1:0]                          ocnt_q, ocnt_d;
  logic                                   ovalid_q, ovalid_d;

  logic                                   accept;
  logic                                   complete;
  logic                                   slot_free;
  logic                                   load;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   merged_vec;
  logic [VECTOR_SIZE-1:0]                 merged_mask;
  logic [NW-1:0]                          merged_cnt;

  // alive_q holds in_ready low until the first edge after reset release
  assign in_ready  = alive_q && (state_q == S_FILL);
  assign out_vec   = ovec_q;
  assign out_mask  = omask_q;
  assign out_count = ocnt_q;
  assign out_valid = ovalid_q;

  always_comb begin
    accept      = in_valid && in_ready;
    complete    = accept && ((cnt_q == NW'(VECTOR_SIZE - 1)) || in_last);
    slot_free   = !ovalid_q || out_ready;

    // Fill contents including this cycle's element, so a completing element
    // can go straight to the output register without a bubble.
    merged_vec  = buf_q;
    merged_mask = mask_q;
    merged_cnt  = cnt_q;
    if (accept) begin
      merged_vec[cnt_q[CW-1:0]]  = in_data;
      merged_mask[cnt_q[CW-1:0]] = 1'b1;
      merged_cnt                 = cnt_q + NW'(1);
    end

    load    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (complete) begin
          if (slot_free) load = 1'b1;
          else           state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    buf_d    = merged_vec;
    mask_d   = merged_mask;
    cnt_d    = merged_cnt;
    ovec_d   = ovec_q;
    omask_d  = omask_q;
    ocnt_d   = ocnt_q;
    ovalid_d = ovalid_q && !out_ready;

    if (load) begin
      ovec_d   = merged_vec;
      omask_d  = merged_mask;
      ocnt_d   = merged_cnt;
      ovalid_d = 1'b1;
      buf_d    = {VECTOR_SIZE{PAD_VALUE}};
      mask_d   = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_FILL;
      alive_q  <= 1'b0;
      cnt_q    <= '0;
      buf_q    <= {VECTOR_SIZE{PAD_VALUE}};
      mask_q   <= '0;
      ovec_q   <= {VECTOR_SIZE{PAD_VALUE}};
      omask_q  <= '0;
      ocnt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      ovec_q   <= ovec_d;
      omask_q  <= omask_d;
      ocnt_q   <= ocnt_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule

// File: doc/vpack.md
Name: vpack

Overview:
- Scalar-stream to vector packer: accepts INT_SIZE elements one per cycle on a valid/ready stream and assembles them into VECTOR_SIZE-lane vectors.
- Produces the packed vector input consumed by the team's vector reduction units (e.g. the pipelined vector max reducer), on a valid/ready output.
- Double-buffered: one fill buffer plus one output register, so filling continues while a completed vector waits for the consumer.
- An in_last marker flushes a partial vector, padded with PAD_VALUE and tagged with a lane mask.

Parameters:
- VECTOR_SIZE, 16, lanes per output vector; power of two, >= 2.
- INT_SIZE, 16, bits per element.
- PAD_VALUE, 0, INT_SIZE-bit value placed in lanes not written before a flush.

Ports:
- clock  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_data  input  INT_SIZE  element data.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualified by in_valid; final element of the current vector (flush).
- in_ready  output  1  block can accept an element this cycle.
- out_vec  output  [VECTOR_SIZE-1:0][INT_SIZE-1:0]  packed vector; element k of a vector in lane k.
- out_mask  output  VECTOR_SIZE  bit k set if lane k holds a real element.
- out_count  output  $clog2(VECTOR_SIZE)+1  number of real elements, 1..VECTOR_SIZE.
- out_valid  output  1  out_vec/out_mask/out_count valid.
- out_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Reset (async, resetn low):
  - Lane counter 0; fill buffer all PAD_VALUE; fill mask 0; state FILL.
  - out_valid 0, out_vec all PAD_VALUE, out_mask 0, out_count 0.
  - in_ready forced 0 while resetn low; 1 from the first cycle after release.
- Accept rule: element accepted on a rising edge where in_valid && in_ready. It is written to fill lane = counter, and the mask bit is set.
- Fill completion: an accepted element completes the fill when counter == VECTOR_SIZE-1 or in_last == 1. Otherwise the counter increments.
- State machine:
  - FILL: in_ready = 1. On completion:
    - If the output slot is free this cycle (out_valid == 0, or out_valid && out_ready), the fill buffer, mask and count load into the output regs; out_valid = 1 the next cycle. The fill buffer resets to PAD/mask 0/counter 0 and the state stays FILL.
    - Otherwise go to FULL.
  - FULL: in_ready = 0. The completed fill is held. When out_valid && out_ready, transfer to the output regs, clear the fill buffer, and return to FILL. in_ready = 1 the following cycle.
- Latency: out_valid asserts the cycle after the completing element is accepted, given a free slot.
- Throughput: sustained one element per cycle when out_ready is held 1; in_ready never drops.
- Output hold: out_vec, out_mask and out_count are stable while out_valid && !out_ready.
- out_valid clears after a handshake unless a new transfer loads the same cycle.
- Simultaneous events:
  - Completion in FILL plus an output handshake in the same cycle: transfer (no bubble).
  - FULL plus handshake: transfer that cycle.
- in_last on element 0 gives a 1-lane vector: mask 0x0001, count 1.
- in_last on lane VECTOR_SIZE-1 behaves the same as a normal full completion.
- in_data and in_last are ignored when in_valid == 0 or in_ready == 0.
- out_count = popcount(out_mask). Real lanes are always contiguous from lane 0.
- Reset mid-operation: the partial fill and any pending output are discarded; no output is produced for them.

Test Plan:
- Full vector: out_ready=1, push 1..16 back-to-back, in_last=0. Expect out_valid in the cycle after the 16th accept; out_vec lane k = k+1; mask 0xFFFF; count 16; in_ready constantly 1.
- Partial flush: push 7, 3, 9 with in_last on 9. Expect lanes 0..2 = 7, 3, 9; lanes 3..15 = PAD_VALUE (0); mask 0x0007; count 3. The next vector starts at lane 0.
- Backpressure: out_ready=0, push 32 elements (values 0..31).
  - First vector (0..15) is held stable.
  - in_ready drops after the 32nd accept and stays 0.
  - Raise out_ready for one cycle: vector 0..15 is consumed; vector 16..31 appears the next cycle with out_valid=1; in_ready returns to 1.
- Zero-bubble: out_ready=1, push 64 elements continuously. Expect 4 vectors with out_valid pulses exactly 16 cycles apart and in_ready never 0. Also check the case where a completion coincides with an output handshake.
- Single-element flush: in_last on the first element (value 0xABCD). Expect lane 0 = 0xABCD, mask 0x0001, count 1.
- Reset mid-operation:
  - Push 5 elements, assert resetn low asynchronously mid-cycle. Expect out_valid=0, mask 0 and in_ready=0 immediately.
  - After release, push 16 new elements. The output contains only the new values; no remnant of the earlier 5.
